// File: rtl/rnbip_ctrl_pkg.sv
// rtl/rnbip_ctrl_pkg.sv - shared types and encodings for the RNBIP-2 control sequencer
package rnbip_ctrl_pkg;

  localparam int OC_W           = 8;
  localparam int DM_TIMEOUT_DEF = 15;
  localparam int WCNT_W         = 4;

  typedef enum logic [3:0] {
    FETCH, DECODE, EX_ALU, OPND, MEM_RD, MEM_WR, SP_ADJ, BRANCH, HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_MOVI, CL_LOAD, CL_STORE, CL_PUSH, CL_POP,
    CL_JMP, CL_CALL, CL_RET, CL_NOP, CL_HALT, CL_ILL
  } cls_t;

  localparam logic [3:0] OP_ALU_LAST = 4'h9;
  localparam logic [3:0] OP_MOVI     = 4'hA;
  localparam logic [3:0] OP_LOAD     = 4'hB;
  localparam logic [3:0] OP_STORE    = 4'hC;
  localparam logic [3:0] OP_STACK    = 4'hD;
  localparam logic [3:0] OP_BRANCH   = 4'hE;
  localparam logic [3:0] OP_SYS      = 4'hF;

  typedef enum logic [1:0] {RW_HOLD = 2'b00, RW_PUSH = 2'b01, RW_POP = 2'b10} rw_t;
  typedef enum logic [1:0] {PC_OR2 = 2'b00, PC_R0 = 2'b01, PC_DM = 2'b10, PC_PM = 2'b11} pc_src_t;
  typedef enum logic [1:0] {MUX_ALU = 2'b00, MUX_DM = 2'b01, MUX_PM = 2'b10} mux_sel_t;

  typedef struct packed {
    logic       l_pc;
    logic       i_pc;
    pc_src_t    pc_src;
    logic       l_ir;
    logic       l_r;
    logic [1:0] enab;
    mux_sel_t   mux_sel;
    logic [3:0] s_af;
    logic       sel_a;
    logic       sel_b;
    logic       s_al;
    rw_t        rw;
    logic       rd;
    logic       wr;
    logic       s5;
    logic       s2;
    logic       halted;
  } ctl_t;

endpackage

// File: rtl/rnbip_ctrl_seq_if.sv
// rtl/rnbip_ctrl_seq_if.sv - opcode/flag inputs and datapath strobes of the sequencer
interface rnbip_ctrl_seq_if;
  import rnbip_ctrl_pkg::*;

  logic [OC_W-1:0] OC;
  logic            FL;
  logic            dm_ack;
  logic            L_PC, I_PC, S11, S10, L_IR, L_R;
  logic [1:0]      enab, mux_sel;
  logic [3:0]      S_AF;
  logic            sel_a, sel_b, S_AL;
  logic [1:0]      rw;
  logic            RD, WR, S5, S2, halted, err;

  modport master (
    input  OC, FL, dm_ack,
    output L_PC, I_PC, S11, S10, L_IR, L_R, enab, mux_sel, S_AF,
           sel_a, sel_b, S_AL, rw, RD, WR, S5, S2, halted, err
  );

  modport slave (
    output OC, FL, dm_ack,
    input  L_PC, I_PC, S11, S10, L_IR, L_R, enab, mux_sel, S_AF,
           sel_a, sel_b, S_AL, rw, RD, WR, S5, S2, halted, err
  );
endinterface

// File: rtl/rnbip_ctrl_decode.sv
// rtl/rnbip_ctrl_decode.sv - combinational opcode classifier: class, register fields, legality
module rnbip_ctrl_decode
  import rnbip_ctrl_pkg::*;
(
  input  logic [OC_W-1:0] oc,
  output cls_t            cls,
  output logic [1:0]      rd_idx,
  output logic [1:0]      rs_idx,
  output logic            cond_always,
  output logic            legal
);

  always_comb begin
    cls = CL_ILL;
    if (oc[7:4] <= OP_ALU_LAST) begin
      cls = CL_ALU;
    end else begin
      case (oc[7:4])
        OP_MOVI:   cls = CL_MOVI;
        OP_LOAD:   cls = CL_LOAD;
        OP_STORE:  cls = CL_STORE;
        OP_STACK:  cls = oc[3] ? CL_POP : CL_PUSH;
        OP_BRANCH: cls = oc[3] ? CL_CALL : CL_JMP;
        OP_SYS: begin
          case (oc[3:0])
            4'h0:    cls = CL_RET;
            4'h1:    cls = CL_NOP;
            4'hF:    cls = CL_HALT;
            default: cls = CL_ILL;
          endcase
        end
        default:   cls = CL_ILL;
      endcase
    end
  end

  // Stack ops spend OC[3] on push/pop, so their register lives in OC[1:0].
  assign rd_idx      = (cls == CL_POP) ? oc[1:0] : oc[3:2];
  assign rs_idx      = oc[1:0];
  assign cond_always = (oc[2:0] == 3'b000);
  assign legal       = (cls != CL_ILL);

endmodule

// File: rtl/rnbip_ctrl_seq.sv
// rtl/rnbip_ctrl_seq.sv - RNBIP-2 multi-cycle control sequencer; all strobes are registered
module rnbip_ctrl_seq
  import rnbip_ctrl_pkg::*;
#(
  parameter int DM_TIMEOUT = DM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  rnbip_ctrl_seq_if.master bus
);

  state_t            state_q, state_d;
  ctl_t              ctl_q, ctl_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;

  cls_t       cls;
  logic [1:0] rd_idx, rs_idx;
  logic       cond_always, legal, mem_timeout;

  rnbip_ctrl_decode u_dec (
    .oc          (bus.OC),
    .cls         (cls),
    .rd_idx      (rd_idx),
    .rs_idx      (rs_idx),
    .cond_always (cond_always),
    .legal       (legal)
  );

  assign mem_timeout = (wcnt_q == WCNT_W'(DM_TIMEOUT - 1));

  // ctl_d always holds the strobes of the state being entered (state_d).
  always_comb begin
    state_d = state_q;
    ctl_d   = '0;
    wcnt_d  = '0;
    err_d   = err_q;
    case (state_q)
      FETCH: if (ctl_q.l_ir) state_d = DECODE;
      DECODE: begin
        if (!legal) err_d = 1'b1;
        case (cls)
          CL_ALU: begin
            state_d       = EX_ALU;
            ctl_d.s_af    = bus.OC[7:4];
            ctl_d.enab    = rd_idx;
            ctl_d.l_r     = 1'b1;
            ctl_d.mux_sel = MUX_ALU;
            ctl_d.s_al    = 1'b1;
            ctl_d.sel_a   = 1'b1;
            ctl_d.sel_b   = 1'b1;
          end
          CL_MOVI: begin
            state_d       = OPND;
            ctl_d.l_r     = 1'b1;
            ctl_d.mux_sel = MUX_PM;
            ctl_d.enab    = rd_idx;
            ctl_d.i_pc    = 1'b1;
          end
          CL_LOAD:  begin state_d = MEM_RD; ctl_d.rd = 1'b1; ctl_d.s5 = 1'b1; ctl_d.enab = rd_idx; end
          CL_STORE: begin state_d = MEM_WR; ctl_d.wr = 1'b1; ctl_d.s5 = 1'b1; ctl_d.enab = rs_idx; end
          CL_PUSH:  begin state_d = SP_ADJ; ctl_d.rw = RW_PUSH; ctl_d.enab = rs_idx; end
          CL_CALL:  begin state_d = SP_ADJ; ctl_d.rw = RW_PUSH; end
          CL_POP, CL_RET: begin state_d = MEM_RD; ctl_d.rd = 1'b1; end
          CL_JMP: begin
            state_d = BRANCH;
            if (bus.FL || cond_always) begin
              ctl_d.l_pc   = 1'b1;
              ctl_d.pc_src = PC_PM;
            end else begin
              ctl_d.i_pc = 1'b1;
            end
          end
          CL_HALT: begin state_d = HALT; ctl_d.halted = 1'b1; end
          default: state_d = FETCH;
        endcase
      end
      // SP_ADJ is the pre-decrement cycle before a push write and the writeback cycle after a read.
      SP_ADJ: begin
        if (cls == CL_PUSH || cls == CL_CALL) begin
          state_d    = MEM_WR;
          ctl_d.wr   = 1'b1;
          ctl_d.s2   = (cls == CL_CALL);
          ctl_d.enab = rs_idx;
        end else begin
          state_d = FETCH;
        end
      end
      MEM_RD: begin
        if (bus.dm_ack) begin
          state_d = SP_ADJ;
          if (cls == CL_RET) begin
            ctl_d.l_pc   = 1'b1;
            ctl_d.pc_src = PC_DM;
          end else begin
            ctl_d.l_r     = 1'b1;
            ctl_d.mux_sel = MUX_DM;
            ctl_d.enab    = rd_idx;
          end
          if (cls != CL_LOAD) ctl_d.rw = RW_POP;
        end else if (mem_timeout) begin
          state_d = FETCH;
          err_d   = 1'b1;
        end else begin
          ctl_d  = ctl_q;
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      MEM_WR: begin
        if (bus.dm_ack) begin
          state_d = (cls == CL_CALL) ? BRANCH : FETCH;
          if (cls == CL_CALL) begin
            ctl_d.l_pc   = 1'b1;
            ctl_d.pc_src = PC_PM;
          end
        end else if (mem_timeout) begin
          state_d = FETCH;
          err_d   = 1'b1;
        end else begin
          ctl_d  = ctl_q;
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      HALT:    ctl_d.halted = 1'b1;
      default: state_d = FETCH;
    endcase
    if (state_d == FETCH) begin
      ctl_d.l_ir = 1'b1;
      ctl_d.i_pc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctl_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.L_PC             = ctl_q.l_pc;
  assign bus.I_PC             = ctl_q.i_pc;
  assign {bus.S11, bus.S10}   = ctl_q.pc_src;
  assign bus.L_IR             = ctl_q.l_ir;
  assign bus.L_R              = ctl_q.l_r;
  assign bus.enab             = ctl_q.enab;
  assign bus.mux_sel          = ctl_q.mux_sel;
  assign bus.S_AF             = ctl_q.s_af;
  assign bus.sel_a            = ctl_q.sel_a;
  assign bus.sel_b            = ctl_q.sel_b;
  assign bus.S_AL             = ctl_q.s_al;
  assign bus.rw               = ctl_q.rw;
  assign bus.RD               = ctl_q.rd;
  assign bus.WR               = ctl_q.wr;
  assign bus.S5               = ctl_q.s5;
  assign bus.S2               = ctl_q.s2;
  assign bus.halted           = ctl_q.halted;
  assign bus.err              = err_q;

endmodule

// File: tb/tb_rnbip_ctrl_seq.sv
// tb/tb_rnbip_ctrl_seq.sv - directed bench for the RNBIP-2 control sequencer
module tb_rnbip_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  rnbip_ctrl_seq_if bus ();
  rnbip_ctrl_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [24:0] outs;
  assign outs = {bus.L_PC, bus.I_PC, bus.S11, bus.S10, bus.L_IR, bus.L_R, bus.enab, bus.mux_sel,
                 bus.S_AF, bus.sel_a, bus.sel_b, bus.S_AL, bus.rw, bus.RD, bus.WR, bus.S5, bus.S2,
                 bus.halted, bus.err};

  int         cyc, mem_cyc, n_rd, n_wr, n_lr, n_lpc, n_ipc, n_push, n_pop, n_sal;
  int         push_cyc, pop_cyc, wr_first, ack_cyc;
  int         both_pc = 0;
  logic [1:0] lr_enab, lr_mux, lpc_src, wr_enab;
  logic [3:0] lr_saf;
  logic       wr_s2, wr_s5, rd_s5, done;
  logic [7:0] sp = 8'h80;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Starts on a FETCH cycle; runs one instruction until the next FETCH (or halt).
  task automatic run_op(input logic [7:0] oc, input int ack_after, input logic fl);
    cyc = 0; mem_cyc = 0; n_rd = 0; n_wr = 0; n_lr = 0; n_lpc = 0; n_ipc = 0;
    n_push = 0; n_pop = 0; n_sal = 0; push_cyc = 0; pop_cyc = 0; wr_first = 0; ack_cyc = 0;
    lr_enab = 0; lr_mux = 0; lpc_src = 0; wr_enab = 0; lr_saf = 0;
    wr_s2 = 0; wr_s5 = 0; rd_s5 = 0; done = 0;
    bus.OC = oc; bus.FL = fl; bus.dm_ack = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.L_PC && bus.I_PC) both_pc++;
      if (bus.L_IR || bus.halted) begin
        done = 1'b1;
      end else begin
        if (bus.RD || bus.WR) begin
          mem_cyc++;
          bus.dm_ack = (ack_after >= 0) && (mem_cyc == ack_after + 1);
          if (bus.dm_ack) ack_cyc = cyc;
        end else begin
          bus.dm_ack = 1'b0;
        end
        if (bus.RD) begin n_rd++; rd_s5 = bus.S5; end
        if (bus.WR) begin
          n_wr++; wr_s2 = bus.S2; wr_s5 = bus.S5; wr_enab = bus.enab;
          if (wr_first == 0) wr_first = cyc;
        end
        if (bus.L_R) begin n_lr++; lr_enab = bus.enab; lr_mux = bus.mux_sel; lr_saf = bus.S_AF; end
        if (bus.S_AL) n_sal++;
        if (bus.L_PC) begin n_lpc++; lpc_src = {bus.S11, bus.S10}; end
        if (bus.I_PC) n_ipc++;
        if (bus.rw == 2'b01) begin n_push++; push_cyc = cyc; sp = sp - 8'd1; end
        if (bus.rw == 2'b10) begin n_pop++; pop_cyc = cyc; sp = sp + 8'd1; end
      end
    end
    bus.dm_ack = 1'b0;
    check_eq("op_reaches_fetch", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.OC = 8'h16; bus.FL = 1'b0; bus.dm_ack = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_all_zero", outs, 0);
    rst_n = 1'b1;

    // ADD R1,R2 straight out of reset
    @(negedge clk);
    check_eq("add_c1_l_ir", bus.L_IR, 1);
    check_eq("add_c1_i_pc", bus.I_PC, 1);
    @(negedge clk);
    check_eq("add_c2_decode_quiet", outs, 0);
    @(negedge clk);
    check_eq("add_c3_s_af", bus.S_AF, 4'h1);
    check_eq("add_c3_enab", bus.enab, 2'd1);
    check_eq("add_c3_l_r", bus.L_R, 1);
    check_eq("add_c3_s_al", bus.S_AL, 1);
    check_eq("add_c3_mux", bus.mux_sel, 2'b00);
    @(negedge clk);
    check_eq("add_c4_fetch", bus.L_IR, 1);

    run_op(8'h9F, -1, 1'b0);
    check_eq("alu9f_cycles", cyc, 3);
    check_eq("alu9f_s_af", lr_saf, 4'h9);
    check_eq("alu9f_enab", lr_enab, 2'd3);
    check_eq("alu9f_s_al", n_sal, 1);

    run_op(8'hB4, 2, 1'b0);
    check_eq("load_rd_cycles", n_rd, 3);
    check_eq("load_s5", rd_s5, 1);
    check_eq("load_l_r_count", n_lr, 1);
    check_eq("load_enab", lr_enab, 2'd1);
    check_eq("load_mux", lr_mux, 2'b01);
    check_eq("load_cycles", cyc, 6);

    run_op(8'hD2, 0, 1'b0);
    check_eq("push_rw_count", n_push, 1);
    check_eq("push_rw_cycle", push_cyc, 2);
    check_eq("push_wr_cycle", wr_first, 3);
    check_eq("push_wr_s5", wr_s5, 0);
    check_eq("push_wr_enab", wr_enab, 2'd2);
    check_eq("push_cycles", cyc, 4);

    run_op(8'hD9, 1, 1'b0);
    check_eq("pop_ack_cycle", ack_cyc, 3);
    check_eq("pop_rw_cycle", pop_cyc, 4);
    check_eq("pop_rw_count", n_pop, 1);
    check_eq("pop_enab", lr_enab, 2'd1);
    check_eq("pop_mux", lr_mux, 2'b01);

    run_op(8'hE1, -1, 1'b0);
    check_eq("jc_nt_i_pc", n_ipc, 1);
    check_eq("jc_nt_l_pc", n_lpc, 0);
    run_op(8'hE1, -1, 1'b1);
    check_eq("jc_t_l_pc", n_lpc, 1);
    check_eq("jc_t_src", lpc_src, 2'b11);
    check_eq("jc_t_i_pc", n_ipc, 0);
    run_op(8'hE0, -1, 1'b0);
    check_eq("jmp_always_l_pc", n_lpc, 1);

    run_op(8'hE8, 0, 1'b0);
    check_eq("call_push", n_push, 1);
    check_eq("call_wr_s2", wr_s2, 1);
    check_eq("call_wr_s5", wr_s5, 0);
    check_eq("call_src", lpc_src, 2'b11);
    check_eq("call_cycles", cyc, 5);

    run_op(8'hF0, 0, 1'b0);
    check_eq("ret_pop", n_pop, 1);
    check_eq("ret_l_pc", n_lpc, 1);
    check_eq("ret_src", lpc_src, 2'b10);
    check_eq("sp_back_to_start", sp, 8'h80);

    run_op(8'hA8, -1, 1'b0);
    check_eq("movi_mux", lr_mux, 2'b10);
    check_eq("movi_enab", lr_enab, 2'd2);
    check_eq("movi_i_pc", n_ipc, 1);

    run_op(8'hF1, -1, 1'b0);
    check_eq("nop_cycles", cyc, 2);
    check_eq("nop_err", bus.err, 0);

    run_op(8'hC3, -1, 1'b0);
    check_eq("store_to_wr_cycles", n_wr, 15);
    check_eq("store_to_s5", wr_s5, 1);
    check_eq("store_to_cycles", cyc, 17);
    check_eq("store_to_err", bus.err, 1);

    // Reset while a store is waiting on its ack
    bus.OC = 8'hC3;
    @(negedge clk);
    @(negedge clk);
    check_eq("midwr_wr_high", bus.WR, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midwr_async_zero", outs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_fetch", bus.L_IR, 1);
    check_eq("post_reset_err", bus.err, 0);

    run_op(8'hF1, -1, 1'b0);
    check_eq("post_reset_no_wr", n_wr, 0);

    run_op(8'hF5, -1, 1'b0);
    check_eq("illegal_cycles", cyc, 2);
    check_eq("illegal_err", bus.err, 1);

    bus.OC = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    check_eq("halt_flag", bus.halted, 1);
    repeat (5) @(negedge clk);
    check_eq("halt_stays_quiet", outs, 25'h3);
    check_eq("never_lpc_and_ipc", both_pc, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
